lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
Load/store unit directly downstream of the execute-stage ALU. It consumes the ALU result as the effective address, plus rs2 store data and funct3. It drives a req/gnt/rvalid data-memory port, builds byte enables and lane-replicated store data, and sign- or zero-extends load data for writeback. The pipeline stalls on lsu_busy while an access is outstanding.

Parameters:
XLEN, 32, datapath width; only 32 is supported (4 byte lanes).
TIMEOUT, 255, maximum cycles spent in REQ or in WAIT before the access is aborted; range 1..255.

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
ex_valid  in  1  EX stage presents an instruction this cycle
ex_memread  in  1  instruction is a load
ex_memwrite  in  1  instruction is a store
ex_funct3  in  3  load: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; store: 000 sb, 001 sh, 010 sw
ex_addr  in  XLEN  effective address (ALU aluout)
ex_wdata  in  XLEN  store data (rs2)
ex_rd  in  5  load destination register
lsu_busy  out  1  access outstanding; stall EX
dmem_req  out  1  memory request
dmem_we  out  1  1 = write
dmem_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00})
dmem_be  out  4  byte enables
dmem_wdata  out  XLEN  lane-replicated store data
dmem_gnt  in  1  request accepted this cycle
dmem_rvalid  in  1  read data valid
dmem_rdata  in  XLEN  read data
wb_valid  out  1  one-cycle pulse: load result ready
wb_rd  out  5  load destination
wb_data  out  XLEN  extended load result
lsu_err  out  1  one-cycle pulse: misaligned, reserved funct3, or timeout
err_addr  out  XLEN  ex_addr of the faulting access

Behaviour:
- All outputs are registered.
- Async reset (rstn=0) sets state to IDLE and forces every output to 0, including lsu_busy, dmem_* and wb_*. This applies at any point, including mid-access.
- States: IDLE, REQ, WAIT. lsu_busy = (state != IDLE).
- Accept: in IDLE with ex_valid=1 and (ex_memread or ex_memwrite), capture addr, wdata, funct3, rd and type. If both memread and memwrite are 1, treat the access as a load. ex_valid is ignored outside IDLE.
- Check, in the accept cycle:
  - Reserved funct3 (load 011/110/111; store not in 000/001/010) is an error.
  - Misaligned is an error: half access with addr[0]=1, or word access with addr[1:0]!=0.
  - On error: no request is issued, state stays IDLE, lsu_err=1 for the next cycle, err_addr=ex_addr.
- Good access: next state is REQ. From the next cycle, dmem_req=1 and dmem_addr/be/we/wdata are held stable until gnt.
- Byte enables and store data:
  - sb: be = 0001 << addr[1:0], wdata = {4{rs2[7:0]}}.
  - sh: be = addr[1] ? 1100 : 0011, wdata = {2{rs2[15:0]}}.
  - sw: be = 1111, wdata = rs2.
  - Loads: dmem_be is set the same way, dmem_we=0.
- REQ, sampled each cycle:
  - gnt=1 on a store: go to IDLE and drop req next cycle. Stores produce no wb_valid.
  - gnt=1 on a load: go to WAIT and drop req.
  - rvalid is ignored while in REQ.
- WAIT: on rvalid=1, go to IDLE and pulse wb_valid=1 for one cycle with wb_rd and wb_data.
  - lane = rdata >> (8*addr[1:0]).
  - lb/lh sign-extend lane[7:0] or lane[15:0]; lbu/lhu zero-extend; lw passes rdata through.
- rvalid or gnt seen in IDLE is ignored; a stale response after reset has no effect.
- Minimum latency: store, accept at cycle 0, req high in cycle 1, gnt in cycle 1, IDLE in cycle 2. Load, with rvalid in cycle 2, gives wb_valid in cycle 3.
- Timeout: an 8-bit counter clears on entry to REQ and to WAIT and increments every cycle spent there. When it equals TIMEOUT with no gnt/rvalid, go to IDLE, drop req, pulse lsu_err, and set err_addr = captured addr. A gnt/rvalid arriving in that same cycle wins over the timeout.
- wb_valid and lsu_err are each high for exactly one cycle per event and are never high together.

Test Plan:
- lw addr 0x100, gnt in first REQ cycle, rvalid next cycle with rdata 0xDEADBEEF -> dmem_addr 0x100, be 1111, we 0; wb_valid one cycle, wb_data 0xDEADBEEF, wb_rd = ex_rd; busy high for exactly 2 cycles.
- lb at 0x103 with rdata 0x80112233 -> wb_data 0xFFFFFF80. lbu, same inputs -> 0x00000080. lhu at 0x102 -> 0x00008011.
- sh addr 0x102, rs2 0x0000ABCD -> dmem_addr 0x100, be 1100, wdata 0xABCDABCD, we 1; no wb_valid. sb at 0x101, rs2 0x12 -> be 0010, wdata 0x12121212.
- lw at 0x102, and sh at 0x001 -> no dmem_req, lsu_err pulse, err_addr 0x102 / 0x001, state stays IDLE. Load with funct3 011 behaves the same.
- gnt held low 3 cycles, then high -> req and address stable for 4 cycles, then completes. With TIMEOUT=4 and gnt never asserted -> req drops after 4 REQ cycles and lsu_err pulses.
- rstn low while in WAIT, rvalid arrives after reset release -> all outputs 0, no wb_valid, next access proceeds normally.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// Load/store unit behind the EX-stage ALU: drives a req/gnt/rvalid data-memory port,
// builds byte enables and lane-replicated store data, and extends load data for writeback.
module lsu_mem_stage #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            ex_valid,
    input  logic            ex_memread,
    input  logic            ex_memwrite,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_addr,
    input  logic [XLEN-1:0] ex_wdata,
    input  logic [4:0]      ex_rd,
    output logic            lsu_busy,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            lsu_err,
    output logic [XLEN-1:0] err_addr,
    output logic [1:0]      dbg_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    // Counter value in the last permitted cycle of REQ or WAIT.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    // Memory port handshake: dmem_req with addr/be/we/wdata stays asserted and stable
    // until a cycle where dmem_gnt=1 is sampled; load data is taken in the first WAIT
    // cycle with dmem_rvalid=1. Responses outside those states are ignored.

    logic [1:0]      state;
    logic [7:0]      cnt;
    logic [XLEN-1:0] addr_q;
    logic [2:0]      f3_q;
    logic [4:0]      rd_q;
    logic            load_q;

    logic            acc;
    logic            acc_load;
    logic            bad_f3;
    logic            misal;
    logic [3:0]      be_c;
    logic [XLEN-1:0] wdata_c;
    logic [15:0]     lane;
    logic [XLEN-1:0] ld_ext;

    assign lsu_busy  = (state != IDLE);
    assign dbg_state = state;

    always_comb begin
        acc      = ex_valid && (ex_memread || ex_memwrite);
        acc_load = ex_memread;
        if (acc_load) begin
            bad_f3 = (ex_funct3 == 3'b011) || (ex_funct3[2:1] == 2'b11);
        end else begin
            bad_f3 = ex_funct3[2] || (ex_funct3[1:0] == 2'b11);
        end
        misal = ((ex_funct3[1:0] == 2'b01) && ex_addr[0]) ||
                ((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00));
        case (ex_funct3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << ex_addr[1:0];
                wdata_c = {4{ex_wdata[7:0]}};
            end
            2'b01: begin
                be_c    = ex_addr[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{ex_wdata[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = ex_wdata;
            end
        endcase
    end

    always_comb begin
        lane = 16'(dmem_rdata >> {addr_q[1:0], 3'b000});
        case (f3_q)
            3'b000:  ld_ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  ld_ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  ld_ext = {24'h0, lane[7:0]};
            3'b101:  ld_ext = {16'h0, lane[15:0]};
            default: ld_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            addr_q     <= '0;
            f3_q       <= 3'd0;
            rd_q       <= 5'd0;
            load_q     <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= 4'd0;
            dmem_wdata <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= 5'd0;
            wb_data    <= '0;
            lsu_err    <= 1'b0;
            err_addr   <= '0;
        end else begin
            wb_valid <= 1'b0;
            lsu_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (acc) begin
                        if (bad_f3 || misal) begin
                            lsu_err  <= 1'b1;
                            err_addr <= ex_addr;
                        end else begin
                            state      <= REQ;
                            cnt        <= 8'd0;
                            dmem_req   <= 1'b1;
                            dmem_we    <= ~acc_load;
                            dmem_addr  <= {ex_addr[XLEN-1:2], 2'b00};
                            dmem_be    <= be_c;
                            dmem_wdata <= wdata_c;
                            addr_q     <= ex_addr;
                            f3_q       <= ex_funct3;
                            rd_q       <= ex_rd;
                            load_q     <= acc_load;
                        end
                    end
                end
                REQ: begin
                    // A grant in the final cycle still wins over the timeout.
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        cnt      <= 8'd0;
                        state    <= load_q ? WAIT : IDLE;
                    end else if (cnt == TO_LAST) begin
                        dmem_req <= 1'b0;
                        state    <= IDLE;
                        lsu_err  <= 1'b1;
                        err_addr <= addr_q;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        state    <= IDLE;
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_q;
                        wb_data  <= ld_ext;
                    end else if (cnt == TO_LAST) begin
                        state    <= IDLE;
                        lsu_err  <= 1'b1;
                        err_addr <= addr_q;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed and randomized checks of lsu_mem_stage against a byte-level reference model,
// with a small access timeout so both timeout paths are reachable.
module tb_lsu_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_memread = 1'b0;
    logic        ex_memwrite = 1'b0;
    logic [2:0]  ex_funct3 = 3'd0;
    logic [31:0] ex_addr = 32'd0;
    logic [31:0] ex_wdata = 32'd0;
    logic [4:0]  ex_rd = 5'd0;
    logic        lsu_busy;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = 32'd0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        lsu_err;
    logic [31:0] err_addr;
    logic [1:0]  dbg_state;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    lsu_mem_stage #(.XLEN(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn),
        .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
        .lsu_busy(lsu_busy), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .lsu_err(lsu_err), .err_addr(err_addr), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard compare ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_bytes(input logic [2:0] f3);
        return 1 << (f3 % 4);
    endfunction

    function automatic bit model_bad(input bit ld, input logic [2:0] f3, input logic [31:0] a);
        bit reserved;
        if (ld) reserved = (f3 == 3) || (f3 == 6) || (f3 == 7);
        else    reserved = (f3 > 2);
        if (reserved) return 1'b1;
        return (a % size_bytes(f3)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int n = size_bytes(f3);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        int n = size_bytes(f3);
        logic [31:0] r = 32'd0;
        for (int i = 0; i < 4; i++) begin
            r = r | (((d >> (8 * (i % n))) & 32'hFF) << (8 * i));
        end
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rdata);
        logic [31:0] v = rdata >> (8 * (a % 4));
        if (size_bytes(f3) == 1) begin
            v = v & 32'hFF;
            if (f3 < 4 && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (size_bytes(f3) == 2) begin
            v = v & 32'hFFFF;
            if (f3 < 4 && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    // ---------------- drivers ----------------
    task automatic quiet();
        ex_valid = 1'b0;
        ex_memread = 1'b0;
        ex_memwrite = 1'b0;
    endtask

    // Offered while busy: must be ignored by the unit.
    task automatic noise();
        ex_valid    = 1'($urandom_range(0, 1));
        ex_memread  = 1'($urandom_range(0, 1));
        ex_memwrite = 1'($urandom_range(0, 1));
        ex_funct3   = 3'($urandom_range(0, 7));
        ex_addr     = $urandom;
        ex_wdata    = $urandom;
        ex_rd       = 5'($urandom_range(0, 31));
    endtask

    task automatic chk_err_pulse(input string tag, input logic [31:0] a);
        chk({tag, "_err"}, 32'(lsu_err), 32'd1);
        chk({tag, "_err_addr"}, err_addr, a);
        chk({tag, "_err_req"}, 32'(dmem_req), 32'd0);
        chk({tag, "_err_busy"}, 32'(lsu_busy), 32'd0);
        chk({tag, "_err_wbv"}, 32'(wb_valid), 32'd0);
        tick();
        chk({tag, "_err_pulse"}, 32'(lsu_err), 32'd0);
    endtask

    task automatic do_access(input string tag, input bit rd_en, input bit wr_en,
                             input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                             input logic [4:0] rd, input int gd, input int rdl,
                             input logic [31:0] rdata);
        bit ld = rd_en;
        logic [31:0] word = a & 32'hFFFF_FFFC;
        ex_valid = 1'b1;
        ex_memread = rd_en;
        ex_memwrite = wr_en;
        ex_funct3 = f3;
        ex_addr = a;
        ex_wdata = wd;
        ex_rd = rd;
        tick();
        quiet();
        if (!rd_en && !wr_en) begin
            chk({tag, "_none_req"}, 32'(dmem_req), 32'd0);
            chk({tag, "_none_busy"}, 32'(lsu_busy), 32'd0);
            chk({tag, "_none_err"}, 32'(lsu_err), 32'd0);
            return;
        end
        if (model_bad(ld, f3, a)) begin
            chk_err_pulse(tag, a);
            return;
        end
        if (ld) exp_q.push_back(model_load(f3, a, rdata));
        for (int i = 0; i <= gd && i < TO; i++) begin
            chk({tag, "_req"}, 32'(dmem_req), 32'd1);
            chk({tag, "_busy"}, 32'(lsu_busy), 32'd1);
            chk({tag, "_addr"}, dmem_addr, word);
            chk({tag, "_be"}, 32'(dmem_be), 32'(model_be(f3, a)));
            chk({tag, "_we"}, 32'(dmem_we), 32'(!ld));
            if (!ld) chk({tag, "_wdata"}, dmem_wdata, model_wdata(f3, wd));
            noise();
            if (i == gd) begin
                dmem_gnt = 1'b1;
                dmem_rvalid = 1'b0;
            end else begin
                dmem_rvalid = 1'($urandom_range(0, 1));
            end
            tick();
            quiet();
            dmem_gnt = 1'b0;
            dmem_rvalid = 1'b0;
        end
        if (gd >= TO) begin
            if (ld) void'(exp_q.pop_back());
            chk_err_pulse({tag, "_req_to"}, a);
            return;
        end
        chk({tag, "_req_drop"}, 32'(dmem_req), 32'd0);
        chk({tag, "_err_none"}, 32'(lsu_err), 32'd0);
        if (!ld) begin
            chk({tag, "_st_busy"}, 32'(lsu_busy), 32'd0);
            chk({tag, "_st_wbv"}, 32'(wb_valid), 32'd0);
            return;
        end
        for (int i = 0; i <= rdl && i < TO; i++) begin
            chk({tag, "_wait_busy"}, 32'(lsu_busy), 32'd1);
            chk({tag, "_wait_wbv"}, 32'(wb_valid), 32'd0);
            noise();
            if (i == rdl) begin
                dmem_rvalid = 1'b1;
                dmem_rdata = rdata;
            end
            tick();
            quiet();
            dmem_rvalid = 1'b0;
            dmem_rdata = $urandom;
        end
        if (rdl >= TO) begin
            void'(exp_q.pop_front());
            chk_err_pulse({tag, "_wait_to"}, a);
            return;
        end
        chk({tag, "_wbv"}, 32'(wb_valid), 32'd1);
        chk({tag, "_wb_rd"}, 32'(wb_rd), 32'(rd));
        chk({tag, "_wb_data"}, wb_data, exp_q.pop_front());
        chk({tag, "_wb_busy"}, 32'(lsu_busy), 32'd0);
        chk({tag, "_wb_err"}, 32'(lsu_err), 32'd0);
        tick();
        chk({tag, "_wb_pulse"}, 32'(wb_valid), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(lsu_busy), 32'd0);
        chk({tag, "_req"}, 32'(dmem_req), 32'd0);
        chk({tag, "_we"}, 32'(dmem_we), 32'd0);
        chk({tag, "_addr"}, dmem_addr, 32'd0);
        chk({tag, "_be"}, 32'(dmem_be), 32'd0);
        chk({tag, "_wdata"}, dmem_wdata, 32'd0);
        chk({tag, "_wbv"}, 32'(wb_valid), 32'd0);
        chk({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
        chk({tag, "_wb_data"}, wb_data, 32'd0);
        chk({tag, "_err"}, 32'(lsu_err), 32'd0);
        chk({tag, "_err_addr"}, err_addr, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #12;
        chk_all_zero("reset");
        tick();
        rstn = 1'b1;
        tick();
        chk_all_zero("post_reset");

        do_access("lw",  1, 0, 3'b010, 32'h100, 32'h0, 5'd5, 0, 0, 32'hDEADBEEF);
        do_access("lb",  1, 0, 3'b000, 32'h103, 32'h0, 5'd6, 0, 0, 32'h80112233);
        do_access("lbu", 1, 0, 3'b100, 32'h103, 32'h0, 5'd7, 0, 1, 32'h80112233);
        do_access("lhu", 1, 0, 3'b101, 32'h102, 32'h0, 5'd8, 1, 0, 32'h80112233);
        do_access("lh",  1, 0, 3'b001, 32'h102, 32'h0, 5'd9, 0, 2, 32'h80112233);
        do_access("sh",  0, 1, 3'b001, 32'h102, 32'h0000ABCD, 5'd0, 0, 0, 32'h0);
        do_access("sb",  0, 1, 3'b000, 32'h101, 32'h00000012, 5'd0, 0, 0, 32'h0);
        do_access("sw",  0, 1, 3'b010, 32'h20C, 32'hCAFEF00D, 5'd0, 2, 0, 32'h0);
        do_access("lw_mis", 1, 0, 3'b010, 32'h102, 32'h0, 5'd1, 0, 0, 32'h0);
        do_access("sh_mis", 0, 1, 3'b001, 32'h001, 32'h0, 5'd1, 0, 0, 32'h0);
        do_access("ld_f3",  1, 0, 3'b011, 32'h100, 32'h0, 5'd1, 0, 0, 32'h0);
        do_access("st_f3",  0, 1, 3'b100, 32'h100, 32'h0, 5'd1, 0, 0, 32'h0);
        do_access("both",   1, 1, 3'b010, 32'h300, 32'h11111111, 5'd3, 0, 0, 32'h01234567);
        do_access("none",   0, 0, 3'b010, 32'h300, 32'h0, 5'd3, 0, 0, 32'h0);
        do_access("gnt_late", 1, 0, 3'b010, 32'h400, 32'h0, 5'd10, TO - 1, TO - 1, 32'h5A5A1234);
        do_access("req_to",   0, 1, 3'b010, 32'h404, 32'h0, 5'd0, TO, 0, 32'h0);
        do_access("wait_to",  1, 0, 3'b010, 32'h408, 32'h0, 5'd11, 0, TO, 32'h0);

        // reset while WAIT; stale rvalid afterwards must be ignored
        ex_valid = 1'b1; ex_memread = 1'b1; ex_memwrite = 1'b0;
        ex_funct3 = 3'b010; ex_addr = 32'h200; ex_rd = 5'd7;
        tick();
        quiet();
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        chk("rst_wait_busy", 32'(lsu_busy), 32'd1);
        #1 rstn = 1'b0;
        #1 chk_all_zero("rst_mid");
        tick();
        rstn = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'h77777777;
        tick();
        dmem_rvalid = 1'b0;
        chk("stale_wbv", 32'(wb_valid), 32'd0);
        chk("stale_busy", 32'(lsu_busy), 32'd0);
        tick();
        chk("stale_wbv2", 32'(wb_valid), 32'd0);
        do_access("after_rst", 1, 0, 3'b010, 32'h500, 32'h0, 5'd12, 0, 0, 32'h13579BDF);

        for (int n = 0; n < 80; n++) begin
            int kind = $urandom_range(0, 9);
            bit r = (kind < 5) || (kind == 8);
            bit w = (kind >= 5);
            logic [2:0] f3 = 3'($urandom_range(0, 7));
            logic [31:0] a = $urandom;
            if (w && !r && $urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2));
            if (r && f3 inside {3'd3, 3'd6, 3'd7} && $urandom_range(0, 3) != 0) f3 = 3'd2;
            if ($urandom_range(0, 3) != 0) a = a & ~32'(size_bytes(f3) - 1);
            do_access("rand", r, w, f3, a, $urandom, 5'($urandom_range(0, 31)),
                      $urandom_range(0, TO), $urandom_range(0, TO), $urandom);
            repeat ($urandom_range(0, 2)) tick();
        end

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
